// File: rtl/hack_mem_pkg.sv
// Shared constants, region decode and screen-buffer record for the Hack data memory.
package hack_mem_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 15;
  localparam int SCR_ADDR_W = 13;
  localparam int RAM_MAX    = 16384;

  localparam logic [ADDR_W-1:0] RAM_LIMIT    = 15'h3FFF;
  localparam logic [ADDR_W-1:0] SCREEN_BASE  = 15'h4000;
  localparam logic [ADDR_W-1:0] SCREEN_LIMIT = 15'h5FFF;
  localparam logic [ADDR_W-1:0] KBD_ADDR     = 15'h6000;

  typedef enum logic [1:0] {
    REGION_RAM    = 2'd0,
    REGION_SCREEN = 2'd1,
    REGION_KBD    = 2'd2,
    REGION_NONE   = 2'd3
  } region_e;

  // One-entry screen write buffer contents
  typedef struct packed {
    logic                  valid;
    logic [SCR_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } scr_buf_t;

  // Map a CPU data address onto its memory region
  function automatic region_e decodeRegion(input logic [ADDR_W-1:0] addr);
    region_e r;
    if (addr <= RAM_LIMIT) begin
      r = REGION_RAM;
    end else if ((addr >= SCREEN_BASE) && (addr <= SCREEN_LIMIT)) begin
      r = REGION_SCREEN;
    end else if (addr == KBD_ADDR) begin
      r = REGION_KBD;
    end else begin
      r = REGION_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/hack_kbd_fifo.sv
// Keyboard key-code FIFO: push/pop with occupancy count; zero codes are
// accepted by the handshake but never stored.
module hack_kbd_fifo
  import hack_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          pushData,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic              isEmpty;
  logic              doStore;
  logic              doPop;

  assign isEmpty = (count == '0);
  assign ready   = (count != CNT_W'(DEPTH));
  assign doStore = push && ready && (pushData != '0);
  assign doPop   = pop && !isEmpty;
  assign head    = isEmpty ? '0 : mem[rdPtr];

  // Storage array: data only, no reset needed
  always_ff @(posedge clk) begin
    if (doStore) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doStore) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({doStore, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hack_data_memory.sv
// Hack computer data memory: RAM, memory-mapped screen with a one-entry
// buffered write port, and a keyboard FIFO at a single address.
module hack_data_memory
  import hack_mem_pkg::*;
#(
  parameter int RAM_WORDS = 16384,
  parameter int KBD_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ADDR_W-1:0]           addressM,
  input  logic                        writeM,
  input  logic [DATA_W-1:0]           outM,
  output logic [DATA_W-1:0]           inM,
  output logic [SCR_ADDR_W-1:0]       scr_addr,
  input  logic [DATA_W-1:0]           scr_rdata,
  output logic                        scr_wr_valid,
  input  logic                        scr_wr_ready,
  output logic [SCR_ADDR_W-1:0]       scr_wr_addr,
  output logic [DATA_W-1:0]           scr_wr_data,
  output logic                        scr_overflow,
  input  logic                        kbd_in_valid,
  output logic                        kbd_in_ready,
  input  logic [DATA_W-1:0]           kbd_in_data,
  output logic [$clog2(KBD_DEPTH):0]  kbd_count
);

  localparam int RAM_AW = $clog2(RAM_WORDS);

  region_e           region;
  logic              ramHit;
  logic [RAM_AW-1:0] ramIdx;
  logic [DATA_W-1:0] ramRdata;
  logic [DATA_W-1:0] ram [RAM_WORDS];

  scr_buf_t          scrBuf;
  logic              scrWrite;
  logic              scrDrain;
  logic              scrAccept;
  logic              overflow;

  logic              kbdPop;
  logic [DATA_W-1:0] kbdHead;

  assign region   = decodeRegion(addressM);
  // Upper part of the RAM window is unimplemented when RAM_WORDS is small
  assign ramHit   = (region == REGION_RAM) && (32'(addressM) < 32'(RAM_WORDS));
  assign ramIdx   = addressM[RAM_AW-1:0];
  assign ramRdata = ram[ramIdx];

  // RAM write port; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (writeM && ramHit) begin
      ram[ramIdx] <= outM;
    end
  end

  assign scr_addr  = addressM[SCR_ADDR_W-1:0];
  assign scrWrite  = writeM && (region == REGION_SCREEN);
  assign scrDrain  = scrBuf.valid && scr_wr_ready;
  // A draining buffer can take a new write on the same edge
  assign scrAccept = scrWrite && (!scrBuf.valid || scrDrain);

  // Screen write buffer: load, drain, and sticky drop flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scrBuf   <= '0;
      overflow <= 1'b0;
    end else begin
      if (scrAccept) begin
        scrBuf <= '{valid: 1'b1, addr: addressM[SCR_ADDR_W-1:0], data: outM};
      end else if (scrDrain) begin
        scrBuf.valid <= 1'b0;
      end
      if (scrWrite && !scrAccept) begin
        overflow <= 1'b1;
      end
    end
  end

  assign scr_wr_valid = scrBuf.valid;
  assign scr_wr_addr  = scrBuf.addr;
  assign scr_wr_data  = scrBuf.data;
  assign scr_overflow = overflow;

  // Any CPU write to the keyboard address consumes the head key code
  assign kbdPop = writeM && (region == REGION_KBD);

  hack_kbd_fifo #(
    .DEPTH(KBD_DEPTH)
  ) u_kbdFifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (kbd_in_valid),
    .pushData (kbd_in_data),
    .pop      (kbdPop),
    .head     (kbdHead),
    .count    (kbd_count),
    .ready    (kbd_in_ready)
  );

  // CPU read-data mux, purely combinational from the address
  always_comb begin
    inM = '0;
    unique case (region)
      REGION_RAM:    inM = ramHit ? ramRdata : '0;
      REGION_SCREEN: inM = scr_rdata;
      REGION_KBD:    inM = kbdHead;
      default:       inM = '0;
    endcase
  end

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed bench for hack_data_memory with a per-cycle reference model.
module tb_hack_data_memory;

  localparam int RAM_WORDS = 1024;
  localparam int KBD_DEPTH = 4;
  localparam int CNT_W     = $clog2(KBD_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [14:0]       addressM = '0;
  logic              writeM = 1'b0;
  logic [15:0]       outM = '0;
  logic [15:0]       inM;
  logic [12:0]       scr_addr;
  logic [15:0]       scr_rdata = 16'hCAFE;
  logic              scr_wr_valid;
  logic              scr_wr_ready = 1'b0;
  logic [12:0]       scr_wr_addr;
  logic [15:0]       scr_wr_data;
  logic              scr_overflow;
  logic              kbd_in_valid = 1'b0;
  logic              kbd_in_ready;
  logic [15:0]       kbd_in_data = '0;
  logic [CNT_W-1:0]  kbd_count;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  // Reference model state
  logic [15:0] mRam [int];
  logic [15:0] mQ [$];
  logic        mValid = 1'b0;
  logic [12:0] mAddr  = '0;
  logic [15:0] mData  = '0;
  logic        mOvf   = 1'b0;

  hack_data_memory #(
    .RAM_WORDS(RAM_WORDS),
    .KBD_DEPTH(KBD_DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .addressM     (addressM),
    .writeM       (writeM),
    .outM         (outM),
    .inM          (inM),
    .scr_addr     (scr_addr),
    .scr_rdata    (scr_rdata),
    .scr_wr_valid (scr_wr_valid),
    .scr_wr_ready (scr_wr_ready),
    .scr_wr_addr  (scr_wr_addr),
    .scr_wr_data  (scr_wr_data),
    .scr_overflow (scr_overflow),
    .kbd_in_valid (kbd_in_valid),
    .kbd_in_ready (kbd_in_ready),
    .kbd_in_data  (kbd_in_data),
    .kbd_count    (kbd_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: behaviour of the memory map at each clock edge
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mValid = 1'b0;
      mAddr  = '0;
      mData  = '0;
      mOvf   = 1'b0;
      mQ.delete();
    end else begin
      bit isScr, drain, pushOk, popOk;
      if (writeM && (int'(addressM) < RAM_WORDS)) mRam[int'(addressM)] = outM;
      isScr  = (addressM >= 15'h4000) && (addressM <= 15'h5FFF);
      drain  = mValid && scr_wr_ready;
      if (writeM && isScr) begin
        if (!mValid || drain) begin
          mValid = 1'b1;
          mAddr  = addressM[12:0];
          mData  = outM;
        end else begin
          mOvf = 1'b1;
        end
      end else if (drain) begin
        mValid = 1'b0;
      end
      pushOk = kbd_in_valid && (mQ.size() < KBD_DEPTH);
      popOk  = writeM && (addressM == 15'h6000) && (mQ.size() > 0);
      if (popOk) void'(mQ.pop_front());
      if (pushOk && (kbd_in_data != 16'h0)) mQ.push_back(kbd_in_data);
    end
  end

  // Expected read data; returns 0 when the addressed RAM word was never written
  function automatic bit expInM(output logic [15:0] v);
    int a;
    a = int'(addressM);
    v = '0;
    if (a <= 'h3FFF) begin
      if (a < RAM_WORDS) begin
        if (!mRam.exists(a)) return 1'b0;
        v = mRam[a];
      end
    end else if (a <= 'h5FFF) begin
      v = scr_rdata;
    end else if (a == 'h6000) begin
      v = (mQ.size() > 0) ? mQ[0] : 16'h0;
    end
    return 1'b1;
  endfunction

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (checkEn) begin
      logic [15:0] ev;
      if (expInM(ev)) check("inM", 32'(inM), 32'(ev));
      check("scr_addr", 32'(scr_addr), 32'(addressM[12:0]));
      check("scr_wr_valid", 32'(scr_wr_valid), 32'(mValid));
      check("scr_wr_addr", 32'(scr_wr_addr), 32'(mAddr));
      check("scr_wr_data", 32'(scr_wr_data), 32'(mData));
      check("scr_overflow", 32'(scr_overflow), 32'(mOvf));
      check("kbd_count", 32'(kbd_count), 32'(mQ.size()));
      check("kbd_in_ready", 32'(kbd_in_ready), 32'(mQ.size() != KBD_DEPTH));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_valid", 32'(scr_wr_valid), 32'h0);
    check("rst_count", 32'(kbd_count), 32'h0);
    check("rst_ready", 32'(kbd_in_ready), 32'h1);
    check("rst_ovf", 32'(scr_overflow), 32'h0);
    checkEn = 1'b1;
    step();
    step();
    reset_n = 1'b1;

    // RAM: write-then-read timing, unimplemented and unmapped addresses
    addressM = 15'h0000; writeM = 1'b1; outM = 16'h5555; step();
    addressM = 15'h0005; outM = 16'h1111; step();
    outM = 16'h1234; #1;
    check("ram_old", 32'(inM), 32'h1111);
    step();
    writeM = 1'b0; #1;
    check("ram_new", 32'(inM), 32'h1234);
    addressM = 15'h2000; writeM = 1'b1; outM = 16'hAAAA; step();
    writeM = 1'b0; #1;
    check("ram_above_words", 32'(inM), 32'h0);
    addressM = 15'h7000; writeM = 1'b1; outM = 16'hBBBB; step();
    writeM = 1'b0; #1;
    check("unmapped_7000", 32'(inM), 32'h0);
    addressM = 15'h0000; #1;
    check("ram_no_alias", 32'(inM), 32'h5555);

    // Screen read path and buffered write with backpressure
    addressM = 15'h4123; scr_rdata = 16'hCAFE; #1;
    check("scr_read", 32'(inM), 32'hCAFE);
    check("scr_addr_lit", 32'(scr_addr), 32'h0123);
    scr_wr_ready = 1'b0;
    addressM = 15'h4010; writeM = 1'b1; outM = 16'hBEEF; step();
    writeM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("scr_hold_valid", 32'(scr_wr_valid), 32'h1);
      check("scr_hold_addr", 32'(scr_wr_addr), 32'h010);
      check("scr_hold_data", 32'(scr_wr_data), 32'hBEEF);
      step();
    end
    scr_wr_ready = 1'b1; step();
    scr_wr_ready = 1'b0; #1;
    check("scr_drained", 32'(scr_wr_valid), 32'h0);

    // Overflow on back-to-back writes
    addressM = 15'h4010; writeM = 1'b1; outM = 16'hBEEF; step();
    addressM = 15'h4020; outM = 16'hDEAD; step();
    writeM = 1'b0; #1;
    check("ovf_flag", 32'(scr_overflow), 32'h1);
    check("ovf_keep_data", 32'(scr_wr_data), 32'hBEEF);
    check("ovf_keep_addr", 32'(scr_wr_addr), 32'h010);

    // Drain and reload on the same edge
    scr_wr_ready = 1'b1; addressM = 15'h4030; writeM = 1'b1; outM = 16'h1357; step();
    scr_wr_ready = 1'b0; writeM = 1'b0; #1;
    check("reload_valid", 32'(scr_wr_valid), 32'h1);
    check("reload_data", 32'(scr_wr_data), 32'h1357);
    check("ovf_sticky", 32'(scr_overflow), 32'h1);
    scr_wr_ready = 1'b1; step();
    scr_wr_ready = 1'b0;

    // Keyboard FIFO fill, full backpressure, pops
    addressM = 15'h6000;
    kbd_in_valid = 1'b1;
    for (int k = 65; k <= 68; k++) begin
      kbd_in_data = 16'(k); step();
    end
    kbd_in_valid = 1'b0; #1;
    check("kbd_full_count", 32'(kbd_count), 32'd4);
    check("kbd_full_ready", 32'(kbd_in_ready), 32'h0);
    check("kbd_head65", 32'(inM), 32'd65);
    kbd_in_valid = 1'b1; kbd_in_data = 16'd69; step();
    kbd_in_valid = 1'b0; #1;
    check("kbd_full_drop", 32'(kbd_count), 32'd4);
    writeM = 1'b1; step();
    writeM = 1'b0; #1;
    check("kbd_pop_head", 32'(inM), 32'd66);
    check("kbd_pop_count", 32'(kbd_count), 32'd3);
    writeM = 1'b1; step();
    kbd_in_valid = 1'b1; kbd_in_data = 16'd70; step();
    kbd_in_valid = 1'b0; writeM = 1'b0; #1;
    check("kbd_pp_count", 32'(kbd_count), 32'd2);
    check("kbd_pp_head", 32'(inM), 32'd68);
    writeM = 1'b1; step();
    writeM = 1'b0; #1;
    check("kbd_order70", 32'(inM), 32'd70);
    kbd_in_valid = 1'b1; kbd_in_data = 16'd0; step();
    kbd_in_valid = 1'b0; #1;
    check("kbd_zero_not_stored", 32'(kbd_count), 32'd1);
    writeM = 1'b1; step();
    writeM = 1'b0; #1;
    check("kbd_empty_read", 32'(inM), 32'h0);
    writeM = 1'b1; kbd_in_valid = 1'b1; kbd_in_data = 16'd80; step();
    writeM = 1'b0; kbd_in_valid = 1'b0; #1;
    check("kbd_empty_pp_count", 32'(kbd_count), 32'd1);
    check("kbd_empty_pp_head", 32'(inM), 32'd80);
    writeM = 1'b1; step();
    writeM = 1'b0;

    // Reset mid-clock with FIFO and screen buffer occupied
    kbd_in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      kbd_in_data = 16'(k); step();
    end
    kbd_in_valid = 1'b0;
    addressM = 15'h4055; writeM = 1'b1; outM = 16'h7777; step();
    writeM = 1'b0; addressM = 15'h6000; #1;
    check("pre_rst_count", 32'(kbd_count), 32'd3);
    check("pre_rst_valid", 32'(scr_wr_valid), 32'h1);
    step();
    #2 reset_n = 1'b0;
    #1;
    check("async_count", 32'(kbd_count), 32'd0);
    check("async_valid", 32'(scr_wr_valid), 32'h0);
    check("async_addr", 32'(scr_wr_addr), 32'h0);
    check("async_data", 32'(scr_wr_data), 32'h0);
    check("async_ovf", 32'(scr_overflow), 32'h0);
    check("async_ready", 32'(kbd_in_ready), 32'h1);
    check("async_kbd_read", 32'(inM), 32'h0);
    addressM = 15'h0005; #1;
    check("ram_survives_rst", 32'(inM), 32'h1234);
    step();
    reset_n = 1'b1;
    step();
    step();
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hack_data_memory.md
HACK_DATA_MEMORY -- requirements
Module: hack_data_memory

Interface
REQ-001 Parameter RAM_WORDS, default 16384: number of implemented RAM words, power of two, at most 16384.
REQ-002 Parameter KBD_DEPTH, default 4: keyboard FIFO entries, power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 addressM  input  15  CPU data address.
REQ-006 writeM  input  1  CPU write strobe for the current cycle.
REQ-007 outM  input  16  CPU write data.
REQ-008 inM  output  16  read data returned to the CPU, combinational from addressM.
REQ-009 scr_addr  output  13  screen read address, equal to addressM[12:0].
REQ-010 scr_rdata  input  16  combinational screen read data from the external frame buffer.
REQ-011 scr_wr_valid / scr_wr_ready  output / input  1 / 1  screen write handshake.
REQ-012 scr_wr_addr / scr_wr_data  output  13 / 16  buffered screen write.
REQ-013 scr_overflow  output  1  sticky flag: a screen write was dropped.
REQ-014 kbd_in_valid / kbd_in_ready  input / output  1 / 1  key-code push handshake.
REQ-015 kbd_in_data  input  16  key code.
REQ-016 kbd_count  output  $clog2(KBD_DEPTH)+1  FIFO occupancy.

Function
REQ-017 The address map SHALL be:
- 0x0000-0x3FFF: RAM.
- 0x4000-0x5FFF: screen.
- 0x6000: KBD.
- All other addresses: reads return 0 and writes are ignored.
REQ-018 RAM read SHALL be combinational. A write with writeM=1 SHALL take effect at the next clock edge, so a same-cycle read returns the old data.
REQ-019 RAM-range addresses at or above RAM_WORDS SHALL read 0 and ignore writes.
REQ-020 A screen-range read SHALL return scr_rdata.
REQ-021 A screen-range write SHALL load the one-entry output buffer at the next edge and assert scr_wr_valid; scr_wr_addr and scr_wr_data SHALL be held stable while scr_wr_valid=1 and scr_wr_ready=0.
REQ-022 The buffer SHALL empty on an edge where scr_wr_valid and scr_wr_ready are both 1.
REQ-023 If the buffer drains on the same edge a new screen write arrives, the new write SHALL be loaded and scr_wr_valid stays 1.
REQ-024 A screen write arriving while the buffer is full and not draining SHALL be dropped, the buffer contents kept, and scr_overflow set until reset.
REQ-025 A KBD read SHALL return the FIFO head, or 0 when the FIFO is empty.
REQ-026 A CPU write to KBD (any data) SHALL pop the FIFO head at the next edge; a pop when empty is ignored.
REQ-027 kbd_in_ready SHALL equal (kbd_count != KBD_DEPTH). A push occurs on an edge with kbd_in_valid=1 and kbd_in_ready=1.
REQ-028 A push with kbd_in_data=0 SHALL be accepted by the handshake but not stored.
REQ-029 A simultaneous push and pop SHALL leave kbd_count unchanged and preserve FIFO order; with the FIFO empty, a pop SHALL be ignored and the push stored.
REQ-030 FIFO pointers SHALL wrap modulo KBD_DEPTH.

Reset
REQ-031 While reset_n=0, the following SHALL hold immediately regardless of clk: scr_wr_valid=0, scr_wr_addr=0, scr_wr_data=0, scr_overflow=0, kbd_count=0, kbd_in_ready=1, FIFO pointers=0.
REQ-032 RAM contents SHALL NOT be cleared by reset.
REQ-033 inM SHALL follow REQ-017 to REQ-025 during reset (KBD reads 0).
REQ-034 A reset asserted while scr_wr_valid=1 SHALL drop the pending screen write without asserting scr_overflow.

Structure
REQ-035 Package hack_mem_pkg SHALL hold the region base/limit constants (SCREEN_BASE=0x4000, KBD_ADDR=0x6000), the data width 16 and the address width 15.
REQ-036 The keyboard FIFO SHALL be a sub-module hack_kbd_fifo (push/pop/head/count). The RAM array and the screen buffer SHALL be inline.

Verification
REQ-037 Write 0x1234 to address 5, then read address 5: inM=old value in the write cycle, 0x1234 in the next cycle; address 0x7000 reads 0.
REQ-038 Screen write 0x4010←0xBEEF with scr_wr_ready=0 for 3 cycles: scr_wr_valid=1, addr=0x010 and data=0xBEEF held; the buffer drains on the ready cycle.
REQ-039 Two screen writes on consecutive cycles with scr_wr_ready=0: second write dropped, scr_overflow=1, buffer still 0xBEEF.
REQ-040 Push key codes 65, 66, 67, 68: kbd_count=4 and kbd_in_ready=0; KBD reads 65; write KBD → reads 66, count=3.
REQ-041 Push 70 and write KBD in the same cycle with count=2: count stays 2 and subsequent pops return the original order.
REQ-042 Assert reset_n=0 mid-clock with count=3 and scr_wr_valid=1: count=0, scr_wr_valid=0 and KBD reads 0 without a clock edge; RAM address 5 still reads 0x1234.
